// File: rtl/lbp_code_streamer.sv
`default_nettype none
// ============================================================================
// Module   : lbp_code_streamer
// Brief    : Turns a channel-interleaved iEEG sample stream into one
//            LBP_LENGTH-bit sign-of-difference code per channel. Codes are
//            published a full frame at a time into a registered output bank
//            that the accelerator drains with send_next_LBP_in.
// Options  : LBP_DEADBAND_EN - a code bit is 1 only when the difference
//            exceeds DEADBAND. When undefined, a plain strict greater-than
//            compare is used and DEADBAND is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module lbp_code_streamer #(
  parameter int E          = 64,
  parameter int LBP_LENGTH = 6,
  parameter int SAMPLE_W   = 16,
  parameter int DEADBAND   = 0
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic [SAMPLE_W-1:0]       sample_in,
  input  logic                      sample_valid_in,
  output logic                      sample_ready_out,
  input  logic                      send_next_LBP_in,
  output logic [E*LBP_LENGTH-1:0]   LBP_codes_out,
  output logic                      codes_valid_out,
  output logic                      frame_err_out
);

  localparam int                  c_CH_W     = (E > 1) ? $clog2(E) : 1;
  localparam int                  c_WARM_W   = $clog2(LBP_LENGTH + 2);
  localparam logic [c_CH_W-1:0]   c_LAST_CH  = c_CH_W'(E - 1);
  // Completed-frame count at which the frame now finishing is the first one
  // whose work registers hold LBP_LENGTH valid difference bits.
  localparam logic [c_WARM_W-1:0] c_WARM_PUB = c_WARM_W'(LBP_LENGTH);
  localparam logic [c_WARM_W-1:0] c_WARM_MAX = c_WARM_W'(LBP_LENGTH + 1);

  typedef enum logic [1:0] {
    S_WARM  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [SAMPLE_W-1:0]       r_prev [E];
  logic [E*LBP_LENGTH-1:0]   r_work;
  logic [E*LBP_LENGTH-1:0]   w_work_upd;
  logic [E*LBP_LENGTH-1:0]   r_codes;
  logic [c_CH_W-1:0]         r_ch;
  logic [c_WARM_W-1:0]       r_warm;
  logic                      r_ready;
  logic                      r_valid;
  logic                      r_err;

  logic                      w_accept;
  logic                      w_frame_done;
  logic                      w_bank_free;
  logic                      w_publish;
  logic                      w_copy;
  logic                      w_bit;
  logic [SAMPLE_W-1:0]       w_prev_cur;

  assign w_accept     = sample_valid_in & r_ready;
  assign w_frame_done = w_accept & (r_ch == c_LAST_CH);
  // The bank can take a new frame if it is empty or is being drained now.
  assign w_bank_free  = ~r_valid | send_next_LBP_in;
  assign w_prev_cur   = r_prev[r_ch];

`ifdef LBP_DEADBAND_EN
  localparam logic signed [SAMPLE_W:0] c_DEADBAND = (SAMPLE_W + 1)'(DEADBAND);
  logic signed [SAMPLE_W:0] w_diff;

  // Difference at one extra bit so it can never overflow, then threshold it.
  always_comb begin
    w_diff = $signed({sample_in[SAMPLE_W-1], sample_in})
           - $signed({w_prev_cur[SAMPLE_W-1], w_prev_cur});
    w_bit  = (w_diff > c_DEADBAND);
  end
`else
  // Code bit is set when the sample rose strictly above the previous one.
  always_comb begin
    w_bit = ($signed(sample_in) > $signed(w_prev_cur));
  end
`endif

  // Shift the new bit into the current channel's code; other channels hold.
  always_comb begin
    w_work_upd = r_work;
    if (w_accept) begin
      w_work_upd[int'(r_ch)*LBP_LENGTH +: LBP_LENGTH] =
        {r_work[int'(r_ch)*LBP_LENGTH +: LBP_LENGTH-1], w_bit};
    end
  end

  // Next-state logic: decide publish, stall, or deferred copy into the bank.
  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_copy      = 1'b0;
    case (r_state)
      S_WARM: begin
        if (w_frame_done && (r_warm == c_WARM_PUB)) begin
          w_publish   = w_bank_free;
          w_state_nxt = w_bank_free ? S_RUN : S_STALL;
        end
      end
      S_RUN: begin
        if (w_frame_done) begin
          w_publish   = w_bank_free;
          w_state_nxt = w_bank_free ? S_RUN : S_STALL;
        end
      end
      S_STALL: begin
        // No samples are taken here, so r_work still holds the finished frame.
        if (send_next_LBP_in) begin
          w_copy      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_WARM;
      end
    endcase
  end

  // State, handshake and output bank registers.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state <= S_WARM;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_codes <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != S_STALL);
      r_err   <= send_next_LBP_in & ~r_valid;
      if (w_publish) begin
        r_codes <= w_work_upd;
        r_valid <= 1'b1;
      end else if (w_copy) begin
        r_codes <= r_work;
        r_valid <= 1'b1;
      end else if (send_next_LBP_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Per-channel history, channel counter and warm-up frame counter.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < E; i++) begin
        r_prev[i] <= '0;
      end
      r_work <= '0;
      r_ch   <= '0;
      r_warm <= '0;
    end else begin
      r_work <= w_work_upd;
      if (w_accept) begin
        r_prev[r_ch] <= sample_in;
        r_ch         <= (r_ch == c_LAST_CH) ? '0 : r_ch + 1'b1;
      end
      if (w_frame_done && (r_warm != c_WARM_MAX)) begin
        r_warm <= r_warm + 1'b1;
      end
    end
  end

  assign sample_ready_out = r_ready;
  assign LBP_codes_out    = r_codes;
  assign codes_valid_out  = r_valid;
  assign frame_err_out    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lbp_code_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbp_code_streamer
// Brief    : Directed bench for lbp_code_streamer (E=4, LBP_LENGTH=6,
//            SAMPLE_W=16, DEADBAND=3). A queue-based model predicts the
//            outputs each cycle; literal expectations pin key scenarios.
// Options  : LBP_DEADBAND_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lbp_code_streamer;

  localparam int E  = 4;
  localparam int L  = 6;
  localparam int W  = 16;
  localparam int DB = 3;

  localparam int SEL_CODES = 0;
  localparam int SEL_VALID = 1;
  localparam int SEL_READY = 2;
  localparam int SEL_ERR   = 3;
  localparam int SEL_CH0   = 4;
  localparam int SEL_CH1   = 5;

`ifdef LBP_DEADBAND_EN
  localparam logic [E*L-1:0] C_RAMP = {E{6'b000000}};
  localparam logic [E*L-1:0] C_F8   = {E{6'b000000}};
  localparam logic [E*L-1:0] C_DBV  = {E{6'b010101}};
`else
  localparam logic [E*L-1:0] C_RAMP = {E{6'b111111}};
  localparam logic [E*L-1:0] C_F8   = {E{6'b111110}};
  localparam logic [E*L-1:0] C_DBV  = {E{6'b110101}};
`endif

  logic           clk = 1'b0;
  logic           rst_in;
  logic [W-1:0]   sample_in;
  logic           sample_valid_in;
  logic           sample_ready_out;
  logic           send_next_LBP_in;
  logic [E*L-1:0] LBP_codes_out;
  logic           codes_valid_out;
  logic           frame_err_out;

  always #5 clk = ~clk;

  lbp_code_streamer #(
    .E          (E),
    .LBP_LENGTH (L),
    .SAMPLE_W   (W),
    .DEADBAND   (DB)
  ) dut (
    .clk              (clk),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .send_next_LBP_in (send_next_LBP_in),
    .LBP_codes_out    (LBP_codes_out),
    .codes_valid_out  (codes_valid_out),
    .frame_err_out    (frame_err_out)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: full per-channel sample history since reset.
  int             hist [E][$];
  int             nsamp;
  logic [E*L-1:0] exp_codes  = '0;
  logic [E*L-1:0] pend_codes = '0;
  bit             exp_valid  = 1'b0;
  bit             exp_ready  = 1'b0;
  bit             exp_err    = 1'b0;
  bit             pending    = 1'b0;

  typedef struct packed {
    logic [7:0]     tag;
    logic [3:0]     sel;
    logic [E*L-1:0] val;
  } lit_t;
  lit_t lit_q [$];
  lit_t cur_lit;

  function automatic bit dbit(input int a, input int b);
`ifdef LBP_DEADBAND_EN
    return (a - b) > DB;
`else
    return a > b;
`endif
  endfunction

  // Code = the last L sign bits of this channel's history, oldest in the MSB.
  function automatic logic [L-1:0] model_code(input int c);
    logic [L-1:0] code = '0;
    int n = hist[c].size();
    for (int k = L; k >= 1; k--) begin
      code = {code[L-2:0], dbit(hist[c][n-k], hist[c][n-k-1])};
    end
    return code;
  endfunction

  function automatic logic [E*L-1:0] model_bank();
    logic [E*L-1:0] b = '0;
    for (int c = 0; c < E; c++) begin
      b[c*L +: L] = model_code(c);
    end
    return b;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [W-1:0] s, input bit sn);
    bit acc;
    bit done;
    if (r) begin
      for (int c = 0; c < E; c++) hist[c].delete();
      nsamp      = 0;
      exp_codes  = '0;
      pend_codes = '0;
      exp_valid  = 1'b0;
      exp_ready  = 1'b0;
      exp_err    = 1'b0;
      pending    = 1'b0;
    end else begin
      acc     = v && exp_ready;
      done    = 1'b0;
      exp_err = sn && !exp_valid;
      if (acc) begin
        hist[nsamp % E].push_back(int'($signed(s)));
        nsamp++;
        done = ((nsamp % E) == 0) && ((nsamp / E) >= L + 1);
      end
      if (pending) begin
        if (sn) begin
          exp_codes = pend_codes;
          pending   = 1'b0;
        end
      end else if (done) begin
        if (!exp_valid || sn) begin
          exp_codes = model_bank();
          exp_valid = 1'b1;
        end else begin
          pend_codes = model_bank();
          pending    = 1'b1;
        end
      end else if (sn) begin
        exp_valid = 1'b0;
      end
      exp_ready = !pending;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [W-1:0] s, input bit sn);
    rst_in           = r;
    sample_valid_in  = v;
    sample_in        = s;
    send_next_LBP_in = sn;
    @(posedge clk);
    model_edge(r, v, s, sn);
    #1;
  endtask

  task automatic lit(input int tag, input int sel, input logic [E*L-1:0] val);
    lit_t l;
    l.tag = tag[7:0];
    l.sel = sel[3:0];
    l.val = val;
    lit_q.push_back(l);
  endtask

  task automatic cmp(input string name, input logic [E*L-1:0] act, input logic [E*L-1:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare the DUT against the model every cycle, then any literal checks.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("codes", LBP_codes_out, exp_codes);
      cmp("valid", {{(E*L-1){1'b0}}, codes_valid_out}, {{(E*L-1){1'b0}}, exp_valid});
      cmp("ready", {{(E*L-1){1'b0}}, sample_ready_out}, {{(E*L-1){1'b0}}, exp_ready});
      cmp("err",   {{(E*L-1){1'b0}}, frame_err_out},   {{(E*L-1){1'b0}}, exp_err});
      while (lit_q.size() > 0) begin
        cur_lit = lit_q.pop_front();
        n_assert++;
        case (int'(cur_lit.sel))
          SEL_CODES: if (LBP_codes_out !== cur_lit.val) begin
            n_fail++;
            $display("FAIL lit%0d codes: got %h expected %h", cur_lit.tag, LBP_codes_out, cur_lit.val);
          end
          SEL_VALID: if (codes_valid_out !== cur_lit.val[0]) begin
            n_fail++;
            $display("FAIL lit%0d valid: got %b expected %b", cur_lit.tag, codes_valid_out, cur_lit.val[0]);
          end
          SEL_READY: if (sample_ready_out !== cur_lit.val[0]) begin
            n_fail++;
            $display("FAIL lit%0d ready: got %b expected %b", cur_lit.tag, sample_ready_out, cur_lit.val[0]);
          end
          SEL_ERR: if (frame_err_out !== cur_lit.val[0]) begin
            n_fail++;
            $display("FAIL lit%0d err: got %b expected %b", cur_lit.tag, frame_err_out, cur_lit.val[0]);
          end
          SEL_CH0: if (LBP_codes_out[5:0] !== 6'b010101 && LBP_codes_out[5:0] !== 6'b101010) begin
            n_fail++;
            $display("FAIL lit%0d ch0: got %b expected 010101 or 101010", cur_lit.tag, LBP_codes_out[5:0]);
          end
          default: if (LBP_codes_out[11:6] !== cur_lit.val[5:0]) begin
            n_fail++;
            $display("FAIL lit%0d ch1: got %b expected %b", cur_lit.tag, LBP_codes_out[11:6], cur_lit.val[5:0]);
          end
        endcase
      end
    end
  end

  task automatic ramp_frames(input int nframes, input int tag_lo);
    for (int f = 0; f < nframes; f++) begin
      for (int c = 0; c < E; c++) step(1'b0, 1'b1, W'(f), 1'b0);
      if (f == L - 1) lit(tag_lo, SEL_VALID, '0);
    end
  endtask

  initial begin
    rst_in = 1'b1; sample_valid_in = 1'b0; sample_in = '0; send_next_LBP_in = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, '0, 1'b0);
    lit(1, SEL_READY, '0); lit(2, SEL_VALID, '0); lit(3, SEL_CODES, '0);
    step(1'b0, 1'b0, '0, 1'b0);
    lit(4, SEL_READY, 1);

    // Warm-up ramp: valid only after the 7th frame completes.
    ramp_frames(L + 1, 5);
    lit(6, SEL_VALID, 1); lit(7, SEL_CODES, C_RAMP);

    // Frame 8 without a drain stalls the stream and leaves the bank alone.
    for (int c = 0; c < E; c++) step(1'b0, 1'b1, '0, 1'b0);
    lit(8, SEL_READY, '0); lit(9, SEL_CODES, C_RAMP);
    step(1'b0, 1'b1, W'(10), 1'b0);
    lit(10, SEL_READY, '0);
    step(1'b0, 1'b1, W'(10), 1'b1);
    lit(11, SEL_CODES, C_F8); lit(12, SEL_VALID, 1); lit(13, SEL_READY, 1);

    // Alternating / constant pattern, drained on the same edge as ch3.
    for (int f = 0; f <= L; f++) begin
      step(1'b0, 1'b1, (f % 2 == 0) ? W'(10) : W'(5), 1'b0);
      step(1'b0, 1'b1, W'(7), 1'b0);
      step(1'b0, 1'b1, W'(f * 20), 1'b0);
      step(1'b0, 1'b1, W'(-f), 1'b1);
      lit(20 + f, SEL_VALID, 1);
    end
    lit(30, SEL_CH0, '0); lit(31, SEL_CH1, '0);

    // Drain, then a spurious drain raises a one-cycle error.
    step(1'b0, 1'b0, '0, 1'b1);
    lit(32, SEL_VALID, '0); lit(33, SEL_ERR, '0);
    step(1'b0, 1'b0, '0, 1'b1);
    lit(34, SEL_ERR, 1);
    step(1'b0, 1'b0, '0, 1'b0);
    lit(35, SEL_ERR, '0);

    // Reset mid-frame at ch2 discards everything; warm-up restarts.
    step(1'b0, 1'b1, W'(1), 1'b0);
    step(1'b0, 1'b1, W'(2), 1'b0);
    step(1'b1, 1'b1, W'(3), 1'b0);
    lit(36, SEL_CODES, '0); lit(37, SEL_VALID, '0); lit(38, SEL_READY, '0);
    step(1'b0, 1'b0, '0, 1'b0);
    ramp_frames(L + 1, 39);
    lit(40, SEL_VALID, 1); lit(41, SEL_CODES, C_RAMP);

    // Difference vector +3,+4,-5,+4,0,+10 on every channel.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    begin
      int vals [7] = '{0, 3, 7, 2, 6, 6, 16};
      for (int f = 0; f < 7; f++) begin
        for (int c = 0; c < E; c++) step(1'b0, 1'b1, W'(vals[f]), 1'b0);
      end
    end
    lit(42, SEL_CODES, C_DBV); lit(43, SEL_VALID, 1);

    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
